// File: rtl/spart_rx_fifo.sv
// SPART receive path: oversampled UART-style receiver with runtime baud divisor,
// parity mode and stop-bit count, feeding a receive FIFO with per-word error tags.
module spart_rx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rxd,
  input  logic [DIV_W-1:0]              divisor,
  input  logic [1:0]                    parity_mode,
  input  logic                          two_stop,
  input  logic                          rx_rd,
  input  logic                          err_clr,
  output logic [DATA_W-1:0]             rx_data,
  output logic                          rx_perr,
  output logic                          rx_ferr,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          err_overrun,
  output logic                          rx_busy,
  output logic [2:0]                    dbg_state
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int WW    = DATA_W + 2;
  localparam logic [3:0]       LAST_BIT = 4'(DATA_W - 1);
  localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP1  = 3'd4,
    S_STOP2  = 3'd5
  } state_t;

  // Handshake: rx_valid means the head outputs hold a stored word; a cycle with
  // rx_valid and rx_rd both high pops it, rx_rd while empty is ignored.

  // ---------------------------------------------------------------- synchroniser
  logic       rxd_q1, rxd_q2, rxd_prev;
  logic [1:0] fill_q;
  logic       line_ok_q;
  logic       fall;

  // line_ok only rises once a genuine high level has passed through the
  // synchroniser, so a line held low across reset release cannot fake an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_q1    <= 1'b1;
      rxd_q2    <= 1'b1;
      rxd_prev  <= 1'b1;
      fill_q    <= 2'd0;
      line_ok_q <= 1'b0;
    end else begin
      rxd_q1   <= rxd;
      rxd_q2   <= rxd_q1;
      rxd_prev <= rxd_q2;
      if (fill_q != 2'd2) fill_q <= fill_q + 2'd1;
      line_ok_q <= line_ok_q | ((fill_q == 2'd2) & rxd_q2);
    end
  end

  assign fall = line_ok_q & rxd_prev & ~rxd_q2;

  // ---------------------------------------------------------------- receiver FSM
  state_t            state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        bit_q, bit_d;
  logic [DATA_W-1:0] shift_q;
  logic              perr_q, perr_d, ferr_q, ferr_d;
  logic [DIV_W-1:0]  div_q;
  logic [1:0]        pmode_q;
  logic              two_q;
  logic              tick, par_en, ld_cfg, shift_en, push;

  assign tick   = (cnt_q == '0);
  assign par_en = (pmode_q == 2'b01) || (pmode_q == 2'b10);

  always_comb begin
    state_d  = state_q;
    cnt_d    = tick ? cnt_q : cnt_q - ONE;
    bit_d    = bit_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    ld_cfg   = 1'b0;
    shift_en = 1'b0;
    push     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fall) begin
          state_d = S_START;
          cnt_d   = (divisor >> 1) - ONE;
          bit_d   = 4'd0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
          ld_cfg  = 1'b1;
        end
      end
      S_START: begin
        if (tick) begin
          cnt_d   = div_q - ONE;
          state_d = rxd_q2 ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_en = 1'b1;
          cnt_d    = div_q - ONE;
          if (bit_q == LAST_BIT) state_d = par_en ? S_PARITY : S_STOP1;
          else                   bit_d   = bit_q + 4'd1;
        end
      end
      S_PARITY: begin
        if (tick) begin
          cnt_d   = div_q - ONE;
          perr_d  = (pmode_q == 2'b10) ? ~(^shift_q ^ rxd_q2) : (^shift_q ^ rxd_q2);
          state_d = S_STOP1;
        end
      end
      S_STOP1: begin
        if (tick) begin
          cnt_d = div_q - ONE;
          if (!rxd_q2) ferr_d = 1'b1;
          if (two_q) begin
            state_d = S_STOP2;
          end else begin
            push    = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_STOP2: begin
        if (tick) begin
          if (!rxd_q2) ferr_d = 1'b1;
          push    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= 4'd0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      div_q   <= '0;
      pmode_q <= 2'b00;
      two_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      if (shift_en) shift_q <= {rxd_q2, shift_q[DATA_W-1:1]};
      if (ld_cfg) begin
        div_q   <= divisor;
        pmode_q <= parity_mode;
        two_q   <= two_stop;
      end
    end
  end

  assign rx_busy   = (state_q != S_IDLE);
  assign dbg_state = state_q;

  // ---------------------------------------------------------------- receive FIFO
  logic [WW-1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full, empty, pop, wr_en, ovr_set;
  logic [WW-1:0]    push_word, head_word;

  assign full      = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign pop       = rx_rd & ~empty;
  assign wr_en     = push & (~full | pop);
  assign ovr_set   = push & full & ~pop;
  assign push_word = {ferr_d, perr_q, shift_q};
  assign rd_ptr_d  = pop ? rd_ptr + AW'(1) : rd_ptr;
  assign count_d   = count_q + CNT_W'(wr_en) - CNT_W'(pop);
  // A word written into the slot about to become head is forwarded directly.
  assign head_word = (wr_en && (wr_ptr == rd_ptr_d)) ? push_word : mem[rd_ptr_d];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      err_overrun <= 1'b0;
      rx_data     <= '0;
      rx_perr     <= 1'b0;
      rx_ferr     <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr  <= rd_ptr_d;
      count_q <= count_d;
      if (ovr_set)      err_overrun <= 1'b1;
      else if (err_clr) err_overrun <= 1'b0;
      if (count_d != '0) begin
        rx_data <= head_word[DATA_W-1:0];
        rx_perr <= head_word[DATA_W];
        rx_ferr <= head_word[DATA_W+1];
      end
    end
  end

  assign rx_valid   = ~empty;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_spart_rx_fifo.sv
// Bench for spart_rx_fifo: frame-level model (expected word queue, push times and
// busy windows derived from the frame timing rules) checked every cycle.
`timescale 1ns/1ps
module tb_spart_rx_fifo;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int DIV_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rxd = 1'b1;
  logic [DIV_W-1:0]  divisor = 16'd32;
  logic [1:0]        parity_mode = 2'b00;
  logic              two_stop = 1'b0;
  logic              rx_rd = 1'b0;
  logic              err_clr = 1'b0;
  logic [DATA_W-1:0] rx_data;
  logic              rx_perr, rx_ferr, rx_valid, err_overrun, rx_busy;
  logic [3:0]        fifo_count;
  logic [2:0]        dbg_state;

  // ---------------------------------------------------------------- clock/reset
  always #5 clk = ~clk;

  spart_rx_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd), .divisor(divisor),
    .parity_mode(parity_mode), .two_stop(two_stop), .rx_rd(rx_rd),
    .err_clr(err_clr), .rx_data(rx_data), .rx_perr(rx_perr),
    .rx_ferr(rx_ferr), .rx_valid(rx_valid), .fifo_count(fifo_count),
    .err_overrun(err_overrun), .rx_busy(rx_busy), .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------- model state
  typedef struct { int due; logic [DATA_W+1:0] w; } frame_t;
  typedef struct { int lo; int hi; } win_t;

  frame_t            sched[$];
  win_t              win[$];
  logic [DATA_W+1:0] exp_q[$];
  bit                m_ovr = 1'b0;
  int                cyc = 0;
  int                n_tests = 0;
  int                n_fail = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic exp_perr(logic [7:0] d, logic p, logic [1:0] mode);
    int ones;
    ones = $countones(d) + int'(p);
    if (mode == 2'b01) return (ones % 2) == 1;
    if (mode == 2'b10) return (ones % 2) == 0;
    return 1'b0;
  endfunction

  // Frame-level model: applies pops and scheduled arrivals at each clock edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        exp_q.delete();
        sched.delete();
        win.delete();
        m_ovr = 1'b0;
      end else begin
        bit do_pop, do_push, set_ovr;
        int sz;
        sz      = exp_q.size();
        do_pop  = rx_rd && (sz > 0);
        do_push = (sched.size() > 0) && (sched[0].due == cyc);
        set_ovr = do_push && (sz == DEPTH) && !do_pop;
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) begin
          if (!set_ovr) exp_q.push_back(sched[0].w);
          void'(sched.pop_front());
        end
        if (set_ovr)      m_ovr = 1'b1;
        else if (err_clr) m_ovr = 1'b0;
      end
    end
  end

  // Scoreboard compare on every falling edge while out of reset.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        bit exp_busy;
        exp_busy = 1'b0;
        foreach (win[i]) if (cyc >= win[i].lo && cyc <= win[i].hi) exp_busy = 1'b1;
        check("valid", rx_valid, exp_q.size() > 0);
        check("count", fifo_count, exp_q.size());
        check("overrun", err_overrun, m_ovr);
        check("busy", rx_busy, exp_busy);
        if (exp_q.size() > 0) begin
          check("head_data", rx_data, exp_q[0][DATA_W-1:0]);
          check("head_perr", rx_perr, exp_q[0][DATA_W]);
          check("head_ferr", rx_ferr, exp_q[0][DATA_W+1]);
        end
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic send_frame(input logic [7:0] d, input int div, input logic [1:0] mode,
                            input logic two, input logic pbit, input logic s1, input logic s2);
    logic   bits[$];
    int     n;
    frame_t f;
    win_t   w;
    @(negedge clk);
    divisor = DIV_W'(div); parity_mode = mode; two_stop = two; rxd = 1'b0;
    n = cyc;
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (mode == 2'b01 || mode == 2'b10) bits.push_back(pbit);
    bits.push_back(s1);
    if (two) bits.push_back(s2);
    f.due = n + 3 + div / 2 + bits.size() * div;
    f.w   = {(!s1 || (two && !s2)), exp_perr(d, pbit, mode), d};
    sched.push_back(f);
    w.lo = n + 3; w.hi = f.due - 1;
    win.push_back(w);
    repeat (div - 1) begin
      @(negedge clk);
      if (cyc == n + 3) begin
        // configuration changes after start detection must not affect this frame
        divisor = DIV_W'(div + 3); parity_mode = ~mode; two_stop = ~two;
      end
    end
    foreach (bits[i]) begin
      @(negedge clk);
      rxd = bits[i];
      repeat (div - 1) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    rxd = 1'b1;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic pop_one();
    @(negedge clk);
    rx_rd = 1'b1;
    @(negedge clk);
    rx_rd = 1'b0;
  endtask

  task automatic summary();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    summary();
    $finish;
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    // reset values
    repeat (3) @(negedge clk);
    check("rst_valid", rx_valid, 0);
    check("rst_busy", rx_busy, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ovr", err_overrun, 0);
    check("rst_data", rx_data, 0);
    check("rst_perr", rx_perr, 0);
    check("rst_ferr", rx_ferr, 0);
    @(negedge clk); #2 rst_n = 1'b1;
    idle(10);

    // 8N1 at div=32: push lands at d+304
    fork
      send_frame(8'hA6, 32, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
      begin
        @(negedge clk);
        repeat (306) @(negedge clk);
        check("push_not_early", fifo_count, 0);
        @(negedge clk);
        check("push_time", fifo_count, 1);
      end
    join
    check("a6_data", rx_data, 8'hA6);
    check("a6_perr", rx_perr, 0);
    check("a6_ferr", rx_ferr, 0);
    pop_one();
    check("a6_drained", rx_valid, 0);

    // parity modes on 0xA6 (four ones)
    send_frame(8'hA6, 32, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1);
    check("even_p1_perr", rx_perr, 1);
    check("even_p1_data", rx_data, 8'hA6);
    pop_one();
    send_frame(8'hA6, 32, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1);
    check("even_p0_perr", rx_perr, 0);
    pop_one();
    send_frame(8'hA6, 32, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1);
    check("odd_p1_perr", rx_perr, 0);
    pop_one();
    send_frame(8'hA6, 16, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1);
    check("odd_p0_perr", rx_perr, 1);
    pop_one();

    // two stop bits, first one bad
    send_frame(8'h5A, 16, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
    check("ferr_tag", rx_ferr, 1);
    check("ferr_data", rx_data, 8'h5A);
    check("ferr_count", fifo_count, 1);
    pop_one();

    // 10-cycle glitch on idle line
    begin
      int n;
      win_t w;
      @(negedge clk);
      divisor = 16'd32; parity_mode = 2'b00; two_stop = 1'b0; rxd = 1'b0;
      n = cyc;
      w.lo = n + 3; w.hi = n + 2 + 16;
      win.push_back(w);
      repeat (10) @(negedge clk);
      rxd = 1'b1;
      repeat (40) @(negedge clk);
      check("glitch_busy", rx_busy, 0);
      check("glitch_count", fifo_count, 0);
    end

    // back-to-back frames at the minimum divisor
    send_frame(8'h00, 4, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    send_frame(8'hFF, 4, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    send_frame(8'h55, 4, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(5);
    check("b2b_count", fifo_count, 3);
    check("b2b_w0", rx_data, 8'h00);
    pop_one();
    check("b2b_w1", rx_data, 8'hFF);
    pop_one();
    check("b2b_w2", rx_data, 8'h55);
    pop_one();

    // overrun: nine words into eight slots
    for (int i = 1; i <= 9; i++) send_frame(8'(8'h10 + i), 8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(5);
    check("ovr_count", fifo_count, 8);
    check("ovr_flag", err_overrun, 1);
    check("ovr_head", rx_data, 8'h11);
    for (int i = 1; i <= 8; i++) begin
      check("ovr_order", rx_data, 8'(8'h10 + i));
      pop_one();
    end
    check("ovr_empty", rx_valid, 0);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    check("ovr_cleared", err_overrun, 0);

    // full FIFO with a pop in the push cycle
    for (int i = 1; i <= 8; i++) send_frame(8'(8'h20 + i), 4, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(3);
    fork
      send_frame(8'h29, 4, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
      begin
        @(negedge clk);
        repeat (40) @(negedge clk);
        rx_rd = 1'b1;
        @(negedge clk);
        rx_rd = 1'b0;
        check("fullpop_count", fifo_count, 8);
        check("fullpop_ovr", err_overrun, 0);
        check("fullpop_head", rx_data, 8'h22);
      end
    join
    for (int i = 0; i < 8; i++) pop_one();
    check("fullpop_empty", rx_valid, 0);

    // reset mid-frame, released with the line still low
    begin
      int n;
      win_t w;
      @(negedge clk);
      divisor = 16'd8; parity_mode = 2'b00; two_stop = 1'b0; rxd = 1'b0;
      n = cyc;
      w.lo = n + 3; w.hi = n + 100000;
      win.push_back(w);
      repeat (8) @(negedge clk);
      rxd = 1'b1;
      repeat (8) @(negedge clk);
      rxd = 1'b0;
      repeat (8) @(negedge clk);
      check("mid_busy", rx_busy, 1);
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_rst_busy", rx_busy, 0);
      check("mid_rst_count", fifo_count, 0);
      @(negedge clk); #2 rst_n = 1'b1;
      repeat (30) @(negedge clk);
      check("held_low_busy", rx_busy, 0);
      check("held_low_count", fifo_count, 0);
      idle(10);
      send_frame(8'h3C, 8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
      idle(3);
      check("post_rst_count", fifo_count, 1);
      check("post_rst_data", rx_data, 8'h3C);
      pop_one();
    end

    idle(5);
    summary();
    $finish;
  end

endmodule

// File: doc/spart_rx_fifo.md
# spart_rx_fifo

Parametrised SPART receive path: oversampled serial-to-parallel receiver with runtime-selectable baud divisor, parity mode and stop-bit count, feeding a receive FIFO with per-word error tags. It replaces the fixed 8N1 receive logic inside the SPART top level, sitting between the `rxd` pin and the bus-side driver, which drains words through a valid/read handshake.

## Interface
- `DATA_W`, 8: data bits per frame, legal 5..9.
- `FIFO_DEPTH`, 8: receive FIFO entries; power of two, ≥2.
- `DIV_W`, 16: width of the baud divisor input.

- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rxd`  in  1  serial input, asynchronous to `clk`, idles high.
- `divisor`  in  DIV_W  clocks per bit; legal ≥4.
- `parity_mode`  in  2  00 none, 01 even, 10 odd, 11 treated as none.
- `two_stop`  in  1  1 = two stop bits are checked.
- `rx_rd`  in  1  pop FIFO head; ignored when empty.
- `err_clr`  in  1  clears sticky `err_overrun`.
- `rx_data`  out  DATA_W  FIFO head data, LSB = first received bit.
- `rx_perr`  out  1  parity error tag of the head word.
- `rx_ferr`  out  1  framing error tag of the head word.
- `rx_valid`  out  1  FIFO non-empty.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  number of stored words.
- `err_overrun`  out  1  sticky; a word arrived while the FIFO was full.
- `rx_busy`  out  1  FSM not in IDLE.

## Operation
- `rxd` passes through a 2-flop synchroniser; both flops and the edge-detect register reset to 1.
- `divisor`, `parity_mode` and `two_stop` are latched at start detection and held for the frame; changes mid-frame have no effect until the next frame.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - IDLE: a synchronised 1→0 transition enters START and loads the bit counter for a half-bit (floor(divisor/2)).
  - START: at counter expiry, if `rxd` is still 0, go to DATA with a full-bit reload; otherwise it is a false start, so return to IDLE with nothing pushed.
  - DATA: sample one bit per `divisor` clocks into a shift register, LSB first. After DATA_W samples, go to PARITY if enabled, else STOP1.
  - PARITY: sample the parity bit. Even mode flags `perr` if the XOR of data and parity bits is 1; odd mode flags it if that XOR is 0.
  - STOP1: sample the stop bit; 0 sets `ferr`. If `two_stop`, go to STOP2, else push and go to IDLE.
  - STOP2: sample again; 0 sets `ferr`. Push and go to IDLE.
- Push happens on the final stop-sample cycle, half-way through the stop bit, so a following start edge is never missed.
- Words with errors are still pushed, with their tags.
- FIFO is circular, with wrapping read/write pointers and a separate count.
  - Full and no pop: the word is dropped, `err_overrun` is set, and contents are unchanged.
  - Full with `rx_rd` in the same cycle: the pop and push both occur and the count is unchanged.
  - Empty with `rx_rd`: no effect.
- `err_clr` and an overrun in the same cycle: the set wins.
- Reset is asynchronous and can occur mid-frame. It returns the FSM to IDLE and empties the FIFO. After release, a start is recognised only on a fresh 1→0 edge, so a line held low does not start a frame.

## Timing
- Reset values: `rx_valid`=0, `rx_busy`=0, `fifo_count`=0, `err_overrun`=0, `rx_data`/`rx_perr`/`rx_ferr`=0.
- Let d be the cycle in which IDLE sees the synchronised falling edge; d is the `rxd` edge plus 2 cycles.
- The start bit is sampled at d+floor(div/2). Bit k (0-based, counting data, then parity, then stops) is sampled at d+floor(div/2)+(k+1)·div.
- Push occurs at the final stop sample. `rx_valid`, `fifo_count` and the head outputs update on the next cycle.
- The head outputs are registered FIFO reads. After `rx_rd`, the next word is presented on the next cycle.
- `rx_busy` rises at d+1 and falls the cycle after the push.

## Test plan
- div=32, 8N1, send 0xA6 (start, bits 0,1,1,0,0,1,0,1, stop) → exactly one push at d+304, `rx_data`=0xA6, `rx_perr`=`rx_ferr`=0, `fifo_count`=1.
- Even parity, send 0xA6 with parity bit 1 → `rx_perr`=1. Repeat with parity bit 0 → `rx_perr`=0. Odd mode with parity 1 → `rx_perr`=0.
- Stop bit driven 0 with `two_stop`=1 and second stop 1 → `rx_ferr`=1, word still pushed. A 10-cycle low glitch on idle `rxd` with div=32 → no push and `rx_busy` back to 0.
- FIFO_DEPTH=8: send 9 words without reads → count 8, `err_overrun`=1, head still word 1. Pop all 8 → words 1..8 in order, `rx_valid`=0. Then `err_clr` → 0.
- Back-to-back frames of 0x00, 0xFF, 0x55 with no idle gap, div=4 (minimum) → all three received correctly.
- Assert `rst_n` low mid DATA, release while `rxd`=0 → no push until `rxd` returns high and a new start edge arrives. That new frame (0x3C) is received correctly.
